// File: rtl/game_ctrl_if.sv
// game_ctrl_if: key/collision/tick inputs and state/score outputs of the game sequencer
interface game_ctrl_if;
  logic game_tick;
  logic start_key;
  logic collision;
  logic [1:0] game_state;
  logic tick_pulse;
  logic [15:0] score;
  logic [15:0] high_score;
  modport master (output game_tick, start_key, collision, input game_state, tick_pulse, score, high_score);
  modport slave (input game_tick, start_key, collision, output game_state, tick_pulse, score, high_score);
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer FSM advancing a saturating BCD score on game ticks
// define GAME_CTRL_HIGH_SCORE_EN to build the high-score register and its END-entry compare
module game_ctrl #(
  parameter int TICKS_PER_POINT = 4
) (
  input logic clk,
  input logic rst_n,
  game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_INIT, S_START, S_END, S_RESET} st_t;
  localparam logic [7:0] LAST = 8'(TICKS_PER_POINT - 1);
  st_t state, state_nx;
  logic tick_q, tick_edge, tick_pulse, pulse_nx, point;
  logic [7:0] pcnt, pcnt_nx;
  logic [15:0] score, score_nx, high_score;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction
  assign tick_edge = bus.game_tick & ~tick_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_INIT;
    else state <= state_nx;
  always_comb
    state_nx = (state == S_INIT && bus.start_key) ? S_START :
               (state == S_START && bus.collision) ? S_END :
               (state == S_END && bus.start_key) ? S_RESET :
               (state == S_RESET) ? S_INIT : state;
  // pcnt is held at zero in INIT, which clears it on entry to START
  always_comb begin
    pulse_nx = tick_edge && state == S_START;
    point = pulse_nx && pcnt == LAST;
    pcnt_nx = (state == S_INIT || state == S_RESET || point) ? 8'd0 : pulse_nx ? pcnt + 8'd1 : pcnt;
    score_nx = (state == S_RESET) ? 16'h0000 :
               (point && !bus.collision && score != 16'h9999) ? bcd_inc(score) : score;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick_q <= 1'b0;
      tick_pulse <= 1'b0;
      pcnt <= 8'd0;
      score <= 16'h0000;
    end else begin
      tick_q <= bus.game_tick;
      tick_pulse <= pulse_nx;
      pcnt <= pcnt_nx;
      score <= score_nx;
    end
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic hs_chk;
  // hs_chk marks the first cycle in END; BCD order matches binary order
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_chk <= 1'b0;
      high_score <= 16'h0000;
    end else begin
      hs_chk <= state == S_START && bus.collision;
      if (hs_chk && score > high_score) high_score <= score;
    end
`else
  assign high_score = 16'h0000;
`endif
  assign bus.game_state = state;
  assign bus.tick_pulse = tick_pulse;
  assign bus.score = score;
  assign bus.high_score = high_score;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl with TICKS_PER_POINT of 4 and 1
module tb_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int pulses = 0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  typedef struct {string tag; logic [15:0] v;} exp_t;
  exp_t q[$];
  game_ctrl_if ia();
  game_ctrl_if ib();
  game_ctrl #(.TICKS_PER_POINT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  game_ctrl #(.TICKS_PER_POINT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  always #5 clk = ~clk;
  function automatic logic [15:0] hs(input logic [15:0] v);
    return HS ? v : 16'h0000;
  endfunction
  task automatic push(input string t, input logic [15:0] v);
    q.push_back('{t, v});
  endtask
  task automatic chk(input logic [15:0] obs);
    exp_t e;
    e = q.pop_front();
    tests++;
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_tick(input bit s, input logic v);
    if (s) ib.game_tick = v;
    else ia.game_tick = v;
  endtask
  task automatic press(input bit s);
    if (s) ib.start_key = 1'b1;
    else ia.start_key = 1'b1;
    step;
    ia.start_key = 1'b0;
    ib.start_key = 1'b0;
  endtask
  task automatic ticks(input bit s, input int n);
    for (int i = 0; i < n; i++) begin
      set_tick(s, 1'b1);
      step;
      if (s ? ib.tick_pulse : ia.tick_pulse) pulses++;
      set_tick(s, 1'b0);
      step;
    end
  endtask
  initial begin
    ia.game_tick = 0; ia.start_key = 0; ia.collision = 0;
    ib.game_tick = 0; ib.start_key = 0; ib.collision = 0;
    for (int i = 0; i < 3; i++) begin
      ia.game_tick = ~ia.game_tick;
      ia.start_key = ~ia.start_key;
      step;
      push("rst_state", 16'h0); chk(16'(ia.game_state));
      push("rst_score", 16'h0); chk(ia.score);
      push("rst_pulse", 16'h0); chk(16'(ia.tick_pulse));
    end
    ia.game_tick = 0; ia.start_key = 0;
    step;
    rst_n = 1'b1;
    step;
    press(0);
    push("start_state", 16'h1); chk(16'(ia.game_state));
    pulses = 0;
    ticks(0, 8);
    push("pulse_count8", 16'd8); chk(16'(pulses));
    push("score_after8", 16'h0002); chk(ia.score);
    ticks(0, 3);
    ia.game_tick = 1; ia.collision = 1;
    step;
    push("coll_state", 16'h2); chk(16'(ia.game_state));
    push("coll_score", 16'h0002); chk(ia.score);
    push("coll_pulse", 16'h1); chk(16'(ia.tick_pulse));
    ia.game_tick = 0; ia.collision = 0;
    step;
    push("hs_update", hs(16'h0002)); chk(ia.high_score);
    press(0);
    push("reset_state", 16'h3); chk(16'(ia.game_state));
    step;
    push("init_state", 16'h0); chk(16'(ia.game_state));
    push("init_score", 16'h0); chk(ia.score);
    push("hs_retained", hs(16'h0002)); chk(ia.high_score);
    press(0);
    ticks(0, 4);
    push("low_score", 16'h0001); chk(ia.score);
    ia.collision = 1;
    step;
    ia.collision = 0;
    step;
    push("hs_not_lowered", hs(16'h0002)); chk(ia.high_score);
    press(0);
    step;
    ib.game_tick = 1;
    step;
    press(1);
    step;
    push("held_tick_ignored", 16'h0); chk(ib.score);
    ib.game_tick = 0;
    step;
    ticks(1, 100);
    push("bcd_carry", 16'h0100); chk(ib.score);
    ticks(1, 9905);
    push("saturate", 16'h9999); chk(ib.score);
    push("dut_a_idle", 16'h0); chk(16'(ia.game_state));
    press(0);
    ticks(0, 167);
    ia.game_tick = 1;
    step;
    push("score_42", 16'h0042); chk(ia.score);
    push("pulse_42", 16'h1); chk(16'(ia.tick_pulse));
    #3 rst_n = 1'b0;
    #1;
    push("async_state", 16'h0); chk(16'(ia.game_state));
    push("async_score", 16'h0); chk(ia.score);
    push("async_pulse", 16'h0); chk(16'(ia.tick_pulse));
    push("async_hs", 16'h0); chk(ia.high_score);
    push("async_b_score", 16'h0); chk(ib.score);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
